// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl_pkg: shared state encoding, defaults and counter sizing for the scan-chain controller
package scan_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, FIN} state_e;
   localparam int DEF_CHAIN_LEN      = 8;
   localparam int DEF_CAPTURE_CYCLES = 1;
   function automatic int cnt_width(input int n, input int c);
      return $clog2((n > c ? n : c) + 1);
   endfunction
endpackage

// File: rtl/scan_shreg.sv
// scan_shreg: parallel-load shift register; shifts toward the MSB with serial input entering bit 0
module scan_shreg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] par_i,
   input  logic         ser_i,
   output logic [W-1:0] q_o,
   output logic         so_o
);
   logic [W-1:0] q_q, q_d;
   always_comb q_d = load_i ? par_i : shift_i ? {q_q[W-2:0], ser_i} : q_q;
   always_ff @(posedge clk) begin
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   end
   assign q_o  = q_q;
   assign so_o = q_q[W-1];
endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: loads a challenge through the scan path, runs a functional capture,
// then unloads the chain tail into a parallel response word
module scan_chain_ctrl
   import scan_ctrl_pkg::*;
#(
   parameter int CHAIN_LEN      = DEF_CHAIN_LEN,
   parameter int CAPTURE_CYCLES = DEF_CAPTURE_CYCLES
) (
   input  logic                 CP,
   input  logic                 RST,
   input  logic                 START,
   input  logic [CHAIN_LEN-1:0] CHAL,
   output logic                 BUSY,
   output logic                 DONE,
   output logic [CHAIN_LEN-1:0] RESP,
   output logic                 TE,
   output logic                 TI,
   output logic                 MASK,
   input  logic                 SO
);
   localparam int N  = CHAIN_LEN;
   localparam int CW = cnt_width(CHAIN_LEN, CAPTURE_CYCLES);
   localparam logic [CW-1:0] N_LAST = CW'(CHAIN_LEN - 1);
   localparam logic [CW-1:0] C_LAST = CW'(CAPTURE_CYCLES - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, last;
   logic          at_last, accept;
   logic          te_q, te_d, mask_q, mask_d, busy_q, busy_d, done_q, done_d;
   logic [N-1:0]  resp_q, resp_d, chal_q, rsr_q;
   logic          chal_so, rsr_so, unused;

   always_comb begin
      last    = state_q == CAPTURE ? C_LAST : (state_q == LOAD || state_q == UNLOAD) ? N_LAST : '0;
      at_last = cnt_q == last;
      accept  = state_q == IDLE && START;
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = START   ? LOAD    : IDLE;
         LOAD:    state_d = at_last ? CAPTURE : LOAD;
         CAPTURE: state_d = at_last ? UNLOAD  : CAPTURE;
         UNLOAD:  state_d = at_last ? FIN     : UNLOAD;
         default: state_d = IDLE;
      endcase
      // counter restarts on every state change and holds at the terminal count
      cnt_d  = state_d != state_q ? '0 : at_last ? cnt_q : cnt_q + CW'(1);
      te_d   = state_d == LOAD || state_d == UNLOAD;
      mask_d = state_d inside {LOAD, CAPTURE, UNLOAD};
      busy_d = state_d != IDLE;
      done_d = state_d == FIN;
      resp_d = state_q == UNLOAD && at_last ? {rsr_q[N-2:0], SO} : resp_q;
   end

   always_ff @(posedge CP) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         te_q    <= 1'b0;
         mask_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         te_q    <= te_d;
         mask_q  <= mask_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         resp_q  <= resp_d;
      end
   end

   // zeros shift in behind the challenge, so its MSB flop is a clean TI: zero outside LOAD
   scan_shreg #(.W(N)) u_chal (
      .clk    (CP),
      .rst    (RST),
      .load_i (accept),
      .shift_i(state_q == LOAD),
      .par_i  (CHAL),
      .ser_i  (1'b0),
      .q_o    (chal_q),
      .so_o   (chal_so)
   );

   scan_shreg #(.W(N)) u_resp (
      .clk    (CP),
      .rst    (RST),
      .load_i (1'b0),
      .shift_i(state_q == UNLOAD),
      .par_i  ('0),
      .ser_i  (SO),
      .q_o    (rsr_q),
      .so_o   (rsr_so)
   );

   assign unused = ^{chal_q, rsr_so, rsr_q[N-1]};
   assign TE     = te_q;
   assign TI     = chal_so;
   assign MASK   = mask_q;
   assign BUSY   = busy_q;
   assign DONE   = done_q;
   assign RESP   = resp_q;
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: two controllers (C=1 and C=3) driving behavioral FD1S2-style chains
module tb_scan_chain_ctrl;
   localparam int N = 4;
   typedef struct {
      int           dut;
      logic [N-1:0] resp;
      int           done_cyc;
      logic [N-1:0] ti;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   start, inv, busy, done, te, ti, mask, so;
   logic [N-1:0] chal [2];
   logic [N-1:0] resp [2];
   logic [N-1:0] chain [2];
   logic [N-1:0] ti_seq [2];
   int           te_cnt [2];
   logic [1:0]   done_prev = 2'b00;
   int           cyc = 0, errors = 0, checks = 0, pushed = 0, seen = 0;
   exp_t         sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   scan_chain_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(1)) dut_a (
      .CP(clk), .RST(rst), .START(start[0]), .CHAL(chal[0]), .BUSY(busy[0]), .DONE(done[0]),
      .RESP(resp[0]), .TE(te[0]), .TI(ti[0]), .MASK(mask[0]), .SO(so[0])
   );

   scan_chain_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(3)) dut_b (
      .CP(clk), .RST(rst), .START(start[1]), .CHAL(chal[1]), .BUSY(busy[1]), .DONE(done[1]),
      .RESP(resp[1]), .TE(te[1]), .TI(ti[1]), .MASK(mask[1]), .SO(so[1])
   );

   // chain model: TE=1 shifts TI in at flop 0; TE=0 captures D=Q or D=~Q
   always @(posedge clk)
      for (int i = 0; i < 2; i++)
         if (rst)        chain[i] <= '0;
         else if (te[i]) chain[i] <= {chain[i][N-2:0], ti[i]};
         else if (inv[i]) chain[i] <= ~chain[i];
   assign so = {chain[1][N-1], chain[0][N-1]};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (!busy[i]) te_cnt[i] = 0;
         else if (te[i]) begin
            if (te_cnt[i] < N) ti_seq[i] = {ti_seq[i][N-2:0], ti[i]};
            te_cnt[i]++;
         end
         if (!busy[i] || done[i]) chk("mask_low_idle_fin", 32'(mask[i]), 0);
         if (done[i]) begin
            seen++;
            chk("done_width", 32'(done_prev[i]), 0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: dut %0d at cycle %0d, expected no DONE", i, cyc);
            end else begin
               e = sb.pop_front();
               chk("done_dut", 32'(i), 32'(e.dut));
               chk("resp", 32'(resp[i]), 32'(e.resp));
               chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
               chk("ti_seq", 32'(ti_seq[i]), 32'(e.ti));
               chk("te_cycles", 32'(te_cnt[i]), 32'(2 * N));
            end
         end
         done_prev[i] = done[i];
      end
   end

   task automatic push(input int d, input logic [N-1:0] r, input int dc, input logic [N-1:0] t);
      exp_t e;
      e.dut = d; e.resp = r; e.done_cyc = dc; e.ti = t;
      sb.push_back(e);
      pushed++;
   endtask

   task automatic go(input int d, input logic [N-1:0] c, input logic [N-1:0] r, input int lat, input bit expect_done);
      @(negedge clk);
      start[d] = 1'b1;
      chal[d]  = c;
      if (expect_done) push(d, r, cyc + lat, c);
      @(negedge clk);
      start[d] = 1'b0;
      chal[d]  = ~c;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || busy != 2'b00) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL wait_idle timeout at cycle %0d: pending %0d, busy %b", cyc, sb.size(), busy);
      end
   endtask

   task automatic chk_cleared(input string tag, input int i);
      chk({tag, "_te"},   32'(te[i]),   0);
      chk({tag, "_ti"},   32'(ti[i]),   0);
      chk({tag, "_mask"}, 32'(mask[i]), 0);
      chk({tag, "_busy"}, 32'(busy[i]), 0);
      chk({tag, "_done"}, 32'(done[i]), 0);
      chk({tag, "_resp"}, 32'(resp[i]), 0);
   endtask

   initial begin
      int t;
      rst = 1'b1; start = 2'b00; inv = 2'b00; chal[0] = '0; chal[1] = '0;
      repeat (3) @(negedge clk);
      chk_cleared("reset_a", 0);
      chk_cleared("reset_b", 1);
      rst = 1'b0;
      go(0, 4'b1011, 4'b1011, 2 * N + 2, 1'b1);
      wait_idle();
      inv[0] = 1'b1;
      go(0, 4'b0110, 4'b1001, 2 * N + 2, 1'b1);
      wait_idle();
      inv[0] = 1'b0;
      go(0, 4'b1011, 4'b1011, 2 * N + 2, 1'b1);
      repeat (2) @(negedge clk);
      start[0] = 1'b1; chal[0] = 4'hF;
      @(negedge clk);
      start[0] = 1'b0;
      wait_idle();
      repeat (2 * N + 4) @(negedge clk);
      go(0, 4'b1011, 4'b0000, 0, 1'b0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_cleared("rst_mid_unload", 0);
      rst = 1'b0;
      go(0, 4'b0001, 4'b0001, 2 * N + 2, 1'b1);
      wait_idle();
      inv[1] = 1'b1;
      go(1, 4'b1100, 4'b0011, 2 * N + 4, 1'b1);
      wait_idle();
      @(negedge clk);
      start[0] = 1'b1; chal[0] = 4'b1010; t = cyc;
      for (int k = 0; k < 3; k++) push(0, 4'b1010, t + k * (2 * N + 3) + 2 * N + 2, 4'b1010);
      repeat (3 * (2 * N + 3) - 10) @(negedge clk);
      start[0] = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);
      chk("done_count", 32'(seen), 32'(pushed));
      chk("scoreboard_empty", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule
